// File: rtl/acap_host_sequencer.sv
// Streams one polynomial into the accumulator BRAM, starts it, waits for done and streams the result back.
// Read-back has RD_LAT+1 cycles of latency, then one word per cycle; out_ready stalls are absorbed by a small FWFT FIFO.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif
`ifndef RING_DEPTH
`define RING_DEPTH 3
`endif

module acap_host_sequencer #(
  parameter int DLEN           = `DATA_SIZE_ARB,
  parameter int RING_DEPTH     = `RING_DEPTH,
  parameter int RD_LAT         = 1,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DLEN-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DLEN-1:0]       out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  acc_we,
  output logic [RING_DEPTH-1:0] acc_waddr,
  output logic [DLEN-1:0]       acc_wdata,
  output logic                  acc_start,
  output logic [RING_DEPTH-1:0] acc_raddr,
  input  logic                  acc_done,
  input  logic [DLEN-1:0]       acc_data_out,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int RING_SIZE  = 1 << RING_DEPTH;
  localparam int FIFO_DEPTH = RD_LAT + 2;
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);
  localparam int TW         = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [RING_DEPTH-1:0] wcnt_q, wcnt_d;
  logic [RING_DEPTH:0]   rcnt_q, rcnt_d;
  logic [RING_DEPTH-1:0] ocnt_q, ocnt_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [RD_LAT-1:0]     vld_q, vld_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic                  acc_we_q, acc_we_d;
  logic [RING_DEPTH-1:0] acc_waddr_q, acc_waddr_d;
  logic [DLEN-1:0]       acc_wdata_q, acc_wdata_d;
  logic                  acc_start_q, acc_start_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [DLEN-1:0]       fifo_q [FIFO_DEPTH];

  logic          in_hs, push, pop, issue;
  logic [CW-1:0] inflight;

  assign in_ready    = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign in_hs       = in_valid && in_ready;
  assign out_valid   = (cnt_q != '0);
  assign out_data    = out_valid ? fifo_q[head_q] : '0;
  assign out_last    = out_valid && (ocnt_q == RING_DEPTH'(RING_SIZE - 1));
  assign pop         = out_valid && out_ready;
  assign push        = vld_q[RD_LAT-1];
  assign busy        = (state_q != S_IDLE);
  assign acc_we      = acc_we_q;
  assign acc_waddr   = acc_waddr_q;
  assign acc_wdata   = acc_wdata_q;
  assign acc_start   = acc_start_q;
  assign acc_raddr   = rcnt_q[RING_DEPTH-1:0];
  assign timeout_err = timeout_err_q;

  // Reads in flight plus words already queued must fit in the FIFO, so a stalled sink never drops data.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_q[i]);
    issue = (state_q == S_DRAIN) && !rcnt_q[RING_DEPTH] &&
            (({1'b0, inflight} + {1'b0, cnt_q}) < (CW + 1)'(FIFO_DEPTH));
  end

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    rcnt_d        = rcnt_q;
    ocnt_d        = ocnt_q;
    tcnt_d        = tcnt_q;
    cnt_d         = cnt_q + CW'(push) - CW'(pop);
    head_d        = head_q;
    tail_d        = tail_q;
    acc_we_d      = in_hs;
    acc_waddr_d   = in_hs ? wcnt_q : acc_waddr_q;
    acc_wdata_d   = in_hs ? in_data : acc_wdata_q;
    acc_start_d   = (state_q == S_START);
    timeout_err_d = timeout_err_q;

    vld_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];

    if (push) tail_d = (tail_q == PW'(FIFO_DEPTH - 1)) ? '0 : tail_q + 1'b1;
    if (pop) begin
      head_d = (head_q == PW'(FIFO_DEPTH - 1)) ? '0 : head_q + 1'b1;
      ocnt_d = ocnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE, S_LOAD: begin
        if (in_hs) begin
          if (state_q == S_IDLE) timeout_err_d = 1'b0;
          wcnt_d  = wcnt_q + 1'b1;
          state_d = (wcnt_q == RING_DEPTH'(RING_SIZE - 1)) ? S_START : S_LOAD;
        end
      end
      S_START: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (acc_done) begin
          rcnt_d  = '0;
          tcnt_d  = '0;
          state_d = S_DRAIN;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tcnt_d        = '0;
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (issue) rcnt_d = rcnt_q + 1'b1;
        if (pop && out_last) begin
          rcnt_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wcnt_q        <= '0;
      rcnt_q        <= '0;
      ocnt_q        <= '0;
      tcnt_q        <= '0;
      vld_q         <= '0;
      cnt_q         <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      acc_we_q      <= 1'b0;
      acc_waddr_q   <= '0;
      acc_wdata_q   <= '0;
      acc_start_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      rcnt_q        <= rcnt_d;
      ocnt_q        <= ocnt_d;
      tcnt_q        <= tcnt_d;
      vld_q         <= vld_d;
      cnt_q         <= cnt_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      acc_we_q      <= acc_we_d;
      acc_waddr_q   <= acc_waddr_d;
      acc_wdata_q   <= acc_wdata_d;
      acc_start_q   <= acc_start_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Storage needs no reset: reads are qualified by cnt_q.
  always_ff @(posedge clk) begin
    if (push) fifo_q[tail_q] <= acc_data_out;
  end

endmodule

// File: tb/tb_acap_host_sequencer.sv
// Bench for acap_host_sequencer: BRAM-style accelerator model returning 2*x, scoreboard on both streams.
module tb_acap_host_sequencer;
  localparam int DLEN = 32, RING_DEPTH = 3, RD_LAT = 1, TO = 16, RS = 8;

  logic clk = 1'b0, reset = 1'b1;
  logic [DLEN-1:0] in_data, out_data, acc_wdata, acc_data_out;
  logic in_valid, in_ready, out_valid, out_last, out_ready;
  logic acc_we, acc_start, acc_done, busy, timeout_err;
  logic [RING_DEPTH-1:0] acc_waddr, acc_raddr;
  logic done_m, done_f;

  always #5 clk = ~clk;
  assign acc_done = done_m | done_f;

  acap_host_sequencer #(.DLEN(DLEN), .RING_DEPTH(RING_DEPTH), .RD_LAT(RD_LAT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .acc_we(acc_we), .acc_waddr(acc_waddr), .acc_wdata(acc_wdata), .acc_start(acc_start),
    .acc_raddr(acc_raddr), .acc_done(acc_done), .acc_data_out(acc_data_out),
    .busy(busy), .timeout_err(timeout_err));

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accelerator model: BRAM holding 2*x, one-cycle read, done pulse done_dly cycles after start.
  logic [DLEN-1:0] bram [RS];
  bit done_en = 1'b1;
  int done_dly = 5;
  initial begin
    logic s_we, s_st;
    logic [RING_DEPTH-1:0] s_wa, s_ra;
    logic [DLEN-1:0] s_wd;
    int dcnt;
    dcnt = 0; done_m = 1'b0; acc_data_out = '0;
    for (int i = 0; i < RS; i++) bram[i] = '0;
    forever begin
      @(posedge clk);
      s_we = acc_we; s_wa = acc_waddr; s_wd = acc_wdata; s_ra = acc_raddr; s_st = acc_start;
      #1;
      if (s_we) bram[s_wa] = 2 * s_wd;
      acc_data_out = bram[s_ra];
      if (dcnt > 0) begin dcnt--; done_m = (dcnt == 0); end
      else done_m = 1'b0;
      if (s_st && done_en) dcnt = done_dly;
    end
  end

  // out_ready pattern: 0 always high, 1 toggle, 2 random, 3 held low.
  int rmode = 0;
  initial begin
    bit rtog;
    rtog = 1'b0; out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: begin out_ready = rtog; rtog = !rtog; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Reference model: accepted inputs must be written to 0..7 in order, and come back doubled in order.
  logic [DLEN-1:0] hs_q[$], exp_q[$];
  int wr_idx = 0, out_idx = 0, cyc = 0, first_cyc = 0, last_cyc = 0, first_we = 0, last_we = 0;
  int starts = 0, polys_done = 0;
  bit prev_last_we = 0, hold_pending = 0, last_hs_prev = 0, to_prev = 0;
  logic [DLEN-1:0] held;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      hs_q.delete(); exp_q.delete();
      wr_idx = 0; out_idx = 0; prev_last_we = 0; hold_pending = 0; last_hs_prev = 0; to_prev = 0;
    end else begin
      if (acc_start) begin
        chk("start_after_last_write", prev_last_we, 1);
        starts++;
      end
      prev_last_we = 0;
      if (acc_we) begin
        chk("write_has_input", hs_q.size() != 0, 1);
        if (hs_q.size() != 0) begin
          logic [DLEN-1:0] v;
          v = hs_q.pop_front();
          chk("waddr", acc_waddr, wr_idx);
          chk("wdata", acc_wdata, v);
          exp_q.push_back(2 * v);
          if (wr_idx == 0) first_we = cyc;
          if (wr_idx == RS - 1) begin last_we = cyc; prev_last_we = 1; end
          wr_idx = (wr_idx + 1) % RS;
        end
      end
      if (in_valid && in_ready) hs_q.push_back(in_data);
      if (hold_pending) chk("out_hold", {out_valid, out_data}, {1'b1, held});
      hold_pending = out_valid && !out_ready;
      held = out_data;
      if (last_hs_prev) chk("idle_after_last", {busy, in_ready}, 2'b01);
      last_hs_prev = 0;
      if (out_valid && out_ready) begin
        chk("out_has_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [DLEN-1:0] e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
          chk("out_last", out_last, out_idx == RS - 1);
          if (out_idx == 0) first_cyc = cyc;
          if (out_idx == RS - 1) begin last_cyc = cyc; polys_done++; last_hs_prev = 1; end
          out_idx = (out_idx + 1) % RS;
        end
      end
      if (timeout_err && !to_prev) begin exp_q.delete(); out_idx = 0; end
      to_prev = timeout_err;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // vm: 0 back-to-back values i+1, 1 in_valid toggling, 2 random valid and data.
  bit vtog = 1'b1;
  task automatic feed(input int vm, input int lo, input int hi, input int done_at);
    for (int i = lo; i < hi; i++) begin
      bit acc;
      int n;
      if (i == done_at) begin
        in_valid = 1'b0; done_f = 1'b1; step(); done_f = 1'b0;
      end
      in_data = (vm == 0) ? DLEN'(i + 1) : DLEN'($urandom);
      acc = 1'b0; n = 0;
      while (!acc && n < 200) begin
        case (vm)
          0: in_valid = 1'b1;
          1: begin in_valid = vtog; vtog = !vtog; end
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        acc = in_valid && in_ready;
        step();
        n++;
      end
      if (!acc) begin chk("feed_accepted", acc, 1); in_valid = 1'b0; return; end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 500);
    chk("idle_reached", busy, 0);
    step();
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_flags"}, {in_ready, out_valid, out_last, acc_we, acc_start, busy, timeout_err}, 7'b1000000);
    chk({tag, "_addrs"}, {acc_waddr, acc_raddr}, '0);
    chk({tag, "_data"}, {out_data, acc_wdata}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int s0, n;
    bit bad, got;
    in_valid = 1'b0; in_data = '0; done_f = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("por");
    reset = 1'b0;
    step();

    // Back-to-back load, immediate drain.
    s0 = starts;
    feed(0, 0, RS, -1);
    wait_idle();
    chk("t1_one_start", starts - s0, 1);
    chk("t1_write_burst", last_we - first_we, RS - 1);
    chk("t1_throughput", last_cyc - first_cyc, RS - 1);

    // Toggling valid and ready.
    rmode = 1; s0 = starts;
    feed(1, 0, RS, -1);
    wait_idle();
    chk("t2_one_start", starts - s0, 1);
    rmode = 0;

    // Sink stalled for 20 cycles in DRAIN.
    rmode = 3;
    feed(0, 0, RS, -1);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    chk("t3_valid_seen", out_valid, 1);
    bad = 1'b0;
    repeat (19) begin
      @(negedge clk);
      if (!out_valid || out_data != 2) bad = 1'b1;
    end
    chk("t3_stall_stable", bad, 0);
    chk("t3_head_data", out_data, 2);
    chk("t3_reads_issued", acc_raddr, 3);
    step();
    rmode = 0;
    wait_idle();
    chk("t3_release_throughput", last_cyc - first_cyc, RS - 1);

    // No done: timeout after exactly TO cycles in WAIT.
    done_en = 1'b0;
    feed(0, 0, RS, -1);
    n = 0;
    do begin @(negedge clk); n++; end while (!acc_start && n < 50);
    chk("t4_start_seen", acc_start, 1);
    repeat (TO - 1) @(negedge clk);
    chk("t4_no_early_timeout", {timeout_err, busy}, 2'b01);
    @(negedge clk);
    chk("t4_timeout_flag", timeout_err, 1);
    chk("t4_idle_ready", {busy, in_ready}, 2'b01);
    step();
    done_en = 1'b1;
    feed(0, 0, 1, -1);
    chk("t4_timeout_cleared", timeout_err, 0);
    feed(0, 1, RS, -1);
    wait_idle();

    // Asynchronous reset at input index 4, then a clean restart.
    feed(0, 0, 4, -1);
    in_valid = 1'b1; in_data = 5;
    #2 reset = 1'b1;
    #1 check_reset_outs("t5_async");
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    feed(0, 0, RS, -1);
    wait_idle();

    // Done pulsed during LOAD must be ignored.
    done_dly = 12; s0 = starts;
    feed(2, 0, RS, 3);
    bad = 1'b0; got = 1'b0; n = 0;
    while (!got && n < 100) begin
      @(negedge clk); n++;
      if (acc_done) got = 1'b1;
      else if (out_valid || acc_raddr != 0 || !busy) bad = 1'b1;
    end
    chk("t6_done_seen", got, 1);
    chk("t6_no_early_read", bad, 0);
    chk("t6_one_start", starts - s0, 1);
    wait_idle();

    // Randomized valid/ready/data/done latency.
    rmode = 2;
    repeat (4) begin
      done_dly = $urandom_range(1, 10);
      feed(2, 0, RS, -1);
      wait_idle();
    end
    rmode = 0;

    chk("polys_completed", polys_done, 10);
    chk("outputs_outstanding", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
